// File: rtl/mca_histogram_if.sv
// Bundle of the histogram's acquisition, control, readout and statistics signals.
// The master side drives events and requests; the slave side is the histogram core.
interface mca_histogram_if #(
  parameter int BIN_BITS = 10,
  parameter int CNT_W    = 32
);
  logic signed [23:0]   peak_in;
  logic                 peak_valid;
  logic                 enable;
  logic                 clear;
  logic                 rd_en;
  logic [BIN_BITS-1:0]  rd_addr;
  logic [CNT_W-1:0]     rd_data;
  logic                 rd_valid;
  logic                 busy;
  logic [CNT_W-1:0]     total_count;
  logic [CNT_W-1:0]     overflow_count;
  logic [CNT_W-1:0]     underflow_count;

  modport master (
    output peak_in, peak_valid, enable, clear, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, total_count, overflow_count, underflow_count
  );

  modport slave (
    input  peak_in, peak_valid, enable, clear, rd_en, rd_addr,
    output rd_data, rd_valid, busy, total_count, overflow_count, underflow_count
  );
endinterface

// File: rtl/mca_histogram.sv
// Multichannel-analyser histogram: bins peak amplitudes into a counter memory
// with a forwarding read-modify-write pipeline, saturating counts and IDLE-only readout.
module mca_histogram #(
  parameter int BIN_BITS = 10,
  parameter int CNT_W    = 32,
  parameter int SHIFT    = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  mca_histogram_if.slave   hist
);

  localparam int             DEPTH   = 1 << BIN_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACQ, DRAIN, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [1:0]          drain_cnt;
  logic [BIN_BITS-1:0] clr_addr;

  logic accept, clr_start, clr_we, rd_accept, busy;

  logic signed [23:0]  shifted;
  logic                is_under, is_over, hit;
  logic [BIN_BITS-1:0] bin_idx;

  logic                s1_vld, s2_vld;
  logic [BIN_BITS-1:0] s1_bin, s2_bin;
  logic [CNT_W-1:0]    s2_cnt, wr_data;

  logic                rd_pend;
  logic [BIN_BITS-1:0] rd_addr_q;

  logic [CNT_W-1:0] total_q, over_q, under_q, rd_data_q;
  logic             rd_valid_q;

  logic [CNT_W-1:0] mem [DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clr_start = 1'b0;
    clr_we    = 1'b0;
    rd_accept = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        rd_accept = hist.rd_en;
        if (hist.clear) begin
          state_nxt = CLEAR;
          clr_start = 1'b1;
        end else if (hist.enable) begin
          state_nxt = ACQ;
        end
      end
      ACQ: begin
        accept = hist.peak_valid;
        if (!hist.enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd2) state_nxt = IDLE;
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_addr == {BIN_BITS{1'b1}}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Non-positive peaks are underflow; any quotient bit above the bin field is overflow.
  assign shifted  = $signed(hist.peak_in) >>> SHIFT;
  assign is_under = hist.peak_in[23] || (hist.peak_in == '0);
  assign is_over  = !is_under && (|shifted[23:BIN_BITS]);
  assign hit      = accept && !is_under && !is_over;
  assign bin_idx  = shifted[BIN_BITS-1:0];
  assign wr_data  = sat_inc(s2_cnt);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      clr_addr   <= '0;
      s1_vld     <= 1'b0;
      s1_bin     <= '0;
      s2_vld     <= 1'b0;
      s2_bin     <= '0;
      s2_cnt     <= '0;
      total_q    <= '0;
      over_q     <= '0;
      under_q    <= '0;
      rd_pend    <= 1'b0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      clr_addr  <= (state == CLEAR) ? clr_addr + BIN_BITS'(1) : '0;

      s1_vld <= hit;
      s1_bin <= bin_idx;
      s2_vld <= s1_vld;
      s2_bin <= s1_bin;
      // The write landing on this same edge is not yet visible in mem, so take it directly.
      s2_cnt <= (s2_vld && (s2_bin == s1_bin)) ? wr_data : mem[s1_bin];

      if (clr_start) begin
        total_q <= '0;
        over_q  <= '0;
        under_q <= '0;
      end else if (accept) begin
        if (is_under)     under_q <= sat_inc(under_q);
        else if (is_over) over_q  <= sat_inc(over_q);
        else              total_q <= sat_inc(total_q);
      end

      rd_pend    <= rd_accept;
      rd_addr_q  <= hist.rd_addr;
      rd_valid_q <= rd_pend;
      if (rd_pend) rd_data_q <= mem[rd_addr_q];
    end
  end

  // NOTE: the bin memory has no reset; its contents are only defined after a CLEAR pass.
  always_ff @(posedge clk) begin
    if (s2_vld)      mem[s2_bin]   <= wr_data;
    else if (clr_we) mem[clr_addr] <= '0;
  end

  assign hist.busy            = busy;
  assign hist.rd_valid        = rd_valid_q;
  assign hist.rd_data         = rd_data_q;
  assign hist.total_count     = total_q;
  assign hist.overflow_count  = over_q;
  assign hist.underflow_count = under_q;

endmodule
